ttl_multi_out: RTL

Parametrised timed TTL output block: accepts timestamped set/clear events over a valid/ready stream, buffers them in an internal FIFO, and applies each event to a NUM_CH-wide registered TTL bank when the global time counter equals the event timestamp. It replaces the fixed 8-channel TTL path behind the AXI-to-FIFO front end. It adds per-channel masking, late-event detection, flush, override and an optional auto-clearing pulse mode. Sits between the AXI2FIFO event writer and the I/O buffer layer. Differential buffering is done outside this block.

---
 rtl/ttl_multi_out_if.sv | 24 ++
 rtl/ttl_multi_out.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ttl_multi_out_if.sv
// Timestamped TTL event stream interface (valid/ready) for ttl_multi_out.
// ev_pulse_len exists only when TTL_MULTI_OUT_PULSE_EN is defined.
interface ttl_multi_out_if #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned TS_LEN  = 64
`ifdef TTL_MULTI_OUT_PULSE_EN
  , parameter int unsigned PULSE_W = 16
`endif
);
  logic              ev_valid;
  logic              ev_ready;
  logic [TS_LEN-1:0] ev_ts;
  logic [NUM_CH-1:0] ev_value;
  logic [NUM_CH-1:0] ev_mask;
`ifdef TTL_MULTI_OUT_PULSE_EN
  logic [PULSE_W-1:0] ev_pulse_len;

  modport master (output ev_valid, ev_ts, ev_value, ev_mask, ev_pulse_len, input ev_ready);
  modport slave  (input ev_valid, ev_ts, ev_value, ev_mask, ev_pulse_len, output ev_ready);
`else
  modport master (output ev_valid, ev_ts, ev_value, ev_mask, input ev_ready);
  modport slave  (input ev_valid, ev_ts, ev_value, ev_mask, output ev_ready);
`endif
endinterface

// File: rtl/ttl_multi_out.sv
// Timed TTL output bank: queues timestamped set/clear events and applies each when counter == ts.
// Optional auto-clearing pulse mode is enabled by defining TTL_MULTI_OUT_PULSE_EN.
module ttl_multi_out #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_LEN = 4,
  parameter int unsigned TS_LEN   = 64
`ifdef TTL_MULTI_OUT_PULSE_EN
  , parameter int unsigned PULSE_W = 16
`endif
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic [TS_LEN-1:0]   counter,
  input  logic                auto_start,
  input  logic                flush,
  ttl_multi_out_if.slave      ev,
  input  logic                override_en,
  input  logic [NUM_CH-1:0]   override_value,
  output logic [NUM_CH-1:0]   ttl_out,
  output logic                counter_matched,
  output logic                late_error,
  output logic [TS_LEN-1:0]   late_error_ts,
  output logic                full,
  output logic                empty,
  output logic [ADDR_LEN:0]   level
);

  localparam int unsigned LVL_W = ADDR_LEN + 1;

  logic [TS_LEN-1:0]   r_ts_mem   [DEPTH];
  logic [NUM_CH-1:0]   r_val_mem  [DEPTH];
  logic [NUM_CH-1:0]   r_mask_mem [DEPTH];
  logic [ADDR_LEN-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_full, r_empty;
  logic [NUM_CH-1:0]   r_shadow, r_ttl;
  logic                r_matched, r_late, r_ready_q;
  logic [TS_LEN-1:0]   r_late_ts;

  logic [TS_LEN-1:0]   w_head_ts;
  logic [NUM_CH-1:0]   w_head_val, w_head_mask, w_shadow_nxt;
  logic                w_push, w_active, w_fire, w_drop, w_pop;
  logic [LVL_W-1:0]    w_level_nxt;

`ifdef TTL_MULTI_OUT_PULSE_EN
  logic [PULSE_W-1:0]  r_plen_mem [DEPTH];
  logic [PULSE_W-1:0]  r_pcnt     [NUM_CH];
  logic [PULSE_W-1:0]  w_pcnt_nxt [NUM_CH];
  logic [PULSE_W-1:0]  w_head_plen;
`endif

  assign r_ready_q   = s_axi_aresetn && !r_full && !flush;
  assign ev.ev_ready = r_ready_q;
  assign w_push      = ev.ev_valid && r_ready_q;

  assign w_head_ts   = r_ts_mem[r_rptr];
  assign w_head_val  = r_val_mem[r_rptr];
  assign w_head_mask = r_mask_mem[r_rptr];

  // Head compare; flush overrides any fire or drop in the same cycle
  assign w_active = auto_start && !r_empty && !flush;
  assign w_fire   = w_active && (w_head_ts == counter);
  assign w_drop   = w_active && (w_head_ts <  counter);
  assign w_pop    = w_fire || w_drop;

  assign w_level_nxt = flush ? '0 : (r_level + LVL_W'(w_push) - LVL_W'(w_pop));

  // Event storage; contents need no reset since pointers define validity
  always_ff @(posedge s_axi_aclk) begin
    if (w_push) begin
      r_ts_mem[r_wptr]   <= ev.ev_ts;
      r_val_mem[r_wptr]  <= ev.ev_value;
      r_mask_mem[r_wptr] <= ev.ev_mask;
`ifdef TTL_MULTI_OUT_PULSE_EN
      r_plen_mem[r_wptr] <= ev.ev_pulse_len;
`endif
    end
  end

`ifdef TTL_MULTI_OUT_PULSE_EN
  assign w_head_plen = r_plen_mem[r_rptr];
`endif

  // Next shadow state: pulse expiries first, then the firing event so a fire wins
  always_comb begin
    w_shadow_nxt = r_shadow;
`ifdef TTL_MULTI_OUT_PULSE_EN
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_pcnt_nxt[i] = r_pcnt[i];
      if (r_pcnt[i] == PULSE_W'(1)) begin
        w_shadow_nxt[i] = 1'b0;
        w_pcnt_nxt[i]   = '0;
      end else if (r_pcnt[i] != '0) begin
        w_pcnt_nxt[i] = r_pcnt[i] - PULSE_W'(1);
      end
    end
`endif
    if (w_fire) begin
      w_shadow_nxt = (w_shadow_nxt & ~w_head_mask) | (w_head_val & w_head_mask);
`ifdef TTL_MULTI_OUT_PULSE_EN
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_head_mask[i]) begin
          w_pcnt_nxt[i] = w_head_val[i] ? w_head_plen : '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_shadow  <= '0;
      r_ttl     <= '0;
      r_matched <= 1'b0;
      r_late    <= 1'b0;
      r_late_ts <= '0;
    end else begin
      if (flush) begin
        r_rptr <= r_wptr;
      end else begin
        if (w_push) r_wptr <= r_wptr + ADDR_LEN'(1);
        if (w_pop)  r_rptr <= r_rptr + ADDR_LEN'(1);
      end
      r_level   <= w_level_nxt;
      r_full    <= (w_level_nxt == LVL_W'(DEPTH));
      r_empty   <= (w_level_nxt == '0);
      r_shadow  <= w_shadow_nxt;
      r_ttl     <= override_en ? override_value : w_shadow_nxt;
      r_matched <= w_fire;
      if (w_drop) begin
        r_late <= 1'b1;
        if (!r_late) r_late_ts <= w_head_ts;
      end
    end
  end

`ifdef TTL_MULTI_OUT_PULSE_EN
  // Per-channel pulse down-counters
  always_ff @(posedge s_axi_aclk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!s_axi_aresetn) r_pcnt[i] <= '0;
      else                r_pcnt[i] <= w_pcnt_nxt[i];
    end
  end
`endif

  assign ttl_out         = r_ttl;
  assign counter_matched = r_matched;
  assign late_error      = r_late;
  assign late_error_ts   = r_late_ts;
  assign full            = r_full;
  assign empty           = r_empty;
  assign level           = r_level;

endmodule
